// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    RSP  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Local code for an abandoned transfer; shares the DECERR encoding.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: turns one command on a valid/ready port into one full
// AXI4-Lite write (AW+W+B) or read (AR+R), then returns data and response on a
// valid/ready response port. One transaction outstanding at a time.
// Optional build macro AXIL_CMD_MASTER_TIMEOUT_EN adds a per-state watchdog
// that abandons a stuck handshake after TIMEOUT_CYCLES and reports 2'b11.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 4,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PROT           = 3'b000,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  r_state;
  state_t                  w_state_next;
  state_t                  w_norm_next;
  logic                    w_accept;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_timeout;

  logic                    r_cmd_ready;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_resp;

  assign w_accept  = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  // A write channel is done once its VALID has already dropped or handshakes now.
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;
  logic          w_busy;

  assign w_busy    = (r_state == WR) || (r_state == WR_B) ||
                     (r_state == RD_A) || (r_state == RD_D);
  // Fires on the last permitted cycle of a state that is not about to advance.
  assign w_timeout = w_busy && (r_timer == TW'(TIMEOUT_CYCLES - 1)) &&
                     (w_norm_next == r_state);

  // Watchdog: restarts on every state change, counts while waiting on the slave.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      r_timer <= '0;
    end else if (w_busy) begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!S_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_state_next;
  end

  // Next-state decode from handshakes; the watchdog overrides to RSP.
  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned (no latch).
    w_norm_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_norm_next = cmd_write ? WR : RD_A;
      WR:      if (w_aw_done && w_w_done) w_norm_next = WR_B;
      WR_B:    if (M_AXI_BVALID && r_bready) w_norm_next = RSP;
      RD_A:    if (M_AXI_ARREADY && r_arvalid) w_norm_next = RD_D;
      RD_D:    if (M_AXI_RVALID && r_rready) w_norm_next = RSP;
      RSP:     if (rsp_ready && r_rsp_valid) w_norm_next = IDLE;
      default: w_norm_next = IDLE;
    endcase
    w_state_next = w_timeout ? RSP : w_norm_next;
  end

  // Registered AXI/response outputs and command capture.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cmd_ready <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= RESP_OKAY;
    end else begin
      r_cmd_ready <= (w_state_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= cmd_write;
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_awvalid <= cmd_write;
            r_wvalid  <= cmd_write;
            r_arvalid <= !cmd_write;
          end
        end
        WR: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_norm_next == WR_B) r_bready <= 1'b1;
        end
        WR_B: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_rdata     <= '0;
            r_resp      <= M_AXI_BRESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RD_A: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        RD_D: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rdata     <= M_AXI_RDATA;
            r_resp      <= M_AXI_RRESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
      if (w_timeout) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_rdata     <= '0;
        r_resp      <= RESP_TIMEOUT;
        r_rsp_valid <= 1'b1;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_write;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: an AXI4-Lite adder-style slave model (regs at
// 0x0/0x4/0xC, 0x8 reads reg0+reg1) with adjustable ready/response behaviour,
// directed commands feeding an expected-response queue, and a monitor that pops
// and compares on every response handshake and watches AXI stability.
module tb_axil_cmd_master;
  import axil_cmd_master_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axil_cmd_master dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- checking ----------------
  typedef struct packed {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- slave model ----------------
  int         aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [1:0] bresp_force = 2'b00;
  bit         ar_hold = 1'b0;

  logic [DW-1:0] regs [4];
  logic          aw_got, w_got, r_pend, s_bvalid, s_rvalid;
  int            aw_cnt, w_cnt, r_cnt;
  logic [AW-1:0] aw_q, ar_q;
  logic [DW-1:0] wd_q, s_rdata;
  logic [SW-1:0] ws_q;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = old_v;
    for (int i = 0; i < SW; i++) if (strb[i]) m[i*8 +: 8] = new_v[i*8 +: 8];
    return m;
  endfunction

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign wready  = wvalid  && !w_got  && (w_cnt  >= w_delay);
  assign arready = arvalid && !ar_hold && !r_pend && !s_rvalid;
  assign bvalid  = s_bvalid;
  assign bresp   = bresp_force;
  assign rvalid  = s_rvalid;
  assign rdata   = s_rdata;
  assign rresp   = RESP_OKAY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_q <= '0; ar_q <= '0; wd_q <= '0; ws_q <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; aw_q <= awaddr; aw_cnt <= 0; end
      else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_got <= 1'b1; wd_q <= wdata; ws_q <= wstrb; w_cnt <= 0; end
      else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
      if (aw_got && w_got) begin
        regs[aw_q[3:2]] <= merge(regs[aw_q[3:2]], wd_q, ws_q);
        aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b1;
      end
      if (s_bvalid && bready) s_bvalid <= 1'b0;
      if (arvalid && arready) begin r_pend <= 1'b1; r_cnt <= 0; ar_q <= araddr; end
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          s_rvalid <= 1'b1; r_pend <= 1'b0;
          s_rdata  <= (ar_q[3:2] == 2'd2) ? regs[0] + regs[1] : regs[ar_q[3:2]];
        end else r_cnt <= r_cnt + 1;
      end
      if (s_rvalid && rready) s_rvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic          p_aw, p_w, p_ar, p_rsp;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_resp;
  logic          p_write;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; p_rsp = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        end
      end
      if (p_aw) begin
        check("awvalid held", 32'(awvalid), 32'd1);
        check("awaddr stable", 32'(awaddr), 32'(p_awaddr));
      end
      if (p_w) begin
        check("wvalid held", 32'(wvalid), 32'd1);
        check("wdata stable", wdata, p_wdata);
        check("wstrb stable", 32'(wstrb), 32'(p_wstrb));
      end
      if (p_ar && !ar_hold) begin
        check("arvalid held", 32'(arvalid), 32'd1);
        check("araddr stable", 32'(araddr), 32'(p_araddr));
      end
      if (p_rsp) begin
        check("rsp_valid held", 32'(rsp_valid), 32'd1);
        check("rsp_rdata stable", rsp_rdata, p_rdata);
        check("rsp_resp stable", 32'(rsp_resp), 32'(p_resp));
        check("rsp_write stable", 32'(rsp_write), 32'(p_write));
      end
      p_aw = awvalid && !awready;     p_awaddr = awaddr;
      p_w  = wvalid && !wready;       p_wdata = wdata; p_wstrb = wstrb;
      p_ar = arvalid && !arready;     p_araddr = araddr;
      p_rsp = rsp_valid && !rsp_ready;
      p_rdata = rsp_rdata; p_resp = rsp_resp; p_write = rsp_write;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input rsp_t e);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_ready wait", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && exp_q.size() == 0) && n < 500) begin @(negedge clk); n++; end
    if (!(cmd_ready && exp_q.size() == 0)) check("idle wait", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin @(negedge clk); n++; end
    if (!rsp_valid) check("rsp_valid wait", 32'd0, 32'd1);
  endtask

  initial begin
    // reset state
    #2;
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    check("reset readies/rsp", {29'd0, bready, rready, rsp_valid}, 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

    // 1: adder programming and read-back
    issue(1'b1, 4'h0, 32'h0000_aaaa, 4'hf, '{1'b1, 32'h0, RESP_OKAY});
    issue(1'b1, 4'h4, 32'hbbbb_0000, 4'hf, '{1'b1, 32'h0, RESP_OKAY});
    issue(1'b1, 4'hc, 32'h0000_0003, 4'hf, '{1'b1, 32'h0, RESP_OKAY});
    issue(1'b0, 4'h8, 32'h0,         4'h0, '{1'b0, 32'hbbbb_aaaa, RESP_OKAY});
    // partial strobe: only the low half-word of reg1 changes
    issue(1'b1, 4'h4, 32'h1234_5678, 4'h3, '{1'b1, 32'h0, RESP_OKAY});
    issue(1'b0, 4'h4, 32'h0,         4'h0, '{1'b0, 32'hbbbb_5678, RESP_OKAY});
    issue(1'b0, 4'hc, 32'h0,         4'h0, '{1'b0, 32'h0000_0003, RESP_OKAY});
    issue(1'b0, 4'h8, 32'h0,         4'h0, '{1'b0, 32'hbbbc_0122, RESP_OKAY});
    wait_idle();

    // 2: AWREADY delayed 3 cycles, W completes first
    aw_delay = 3;
    issue(1'b1, 4'h0, 32'hdead_beef, 4'hf, '{1'b1, 32'h0, RESP_OKAY});
    @(negedge clk);
    @(negedge clk);
    check("W dropped first", 32'(wvalid), 32'd0);
    check("AW still pending", 32'(awvalid), 32'd1);
    wait_idle();
    aw_delay = 0;
    issue(1'b0, 4'h0, 32'h0, 4'h0, '{1'b0, 32'hdead_beef, RESP_OKAY});
    wait_idle();

    // 3: response held off 5 cycles
    rsp_ready = 1'b0;
    issue(1'b1, 4'hc, 32'h0000_0001, 4'hf, '{1'b1, 32'h0, RESP_OKAY});
    wait_rsp_valid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("cmd_ready low in RSP", 32'(cmd_ready), 32'd0);
      check("no AXI activity", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // 5: SLVERR passed through
    bresp_force = RESP_SLVERR;
    issue(1'b1, 4'h4, 32'h0000_0055, 4'hf, '{1'b1, 32'h0, RESP_SLVERR});
    wait_idle();
    bresp_force = RESP_OKAY;

    // 4: reset while waiting for read data
    r_delay = 50;
    issue(1'b0, 4'h0, 32'h0, 4'h0, '{1'b0, 32'h0, RESP_OKAY});
    begin
      int n = 0;
      while (!rready && n < 50) begin @(negedge clk); n++; end
      check("reached RD_D", 32'(rready), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst arvalid", 32'(arvalid), 32'd0);
    check("rst rready", 32'(rready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    r_delay = 0;
    #14 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready after rst", 32'(cmd_ready), 32'd1);
    issue(1'b0, 4'hc, 32'h0, 4'h0, '{1'b0, 32'h0, RESP_OKAY});
    wait_idle();

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // 6: ARREADY never comes
    ar_hold = 1'b1;
    issue(1'b0, 4'h4, 32'h0, 4'h0, '{1'b0, 32'h0, RESP_TIMEOUT});
    wait_rsp_valid(400);
    check("timeout arvalid low", 32'(arvalid), 32'd0);
    wait_idle();
    ar_hold = 1'b0;
`endif

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
